// File: rtl/pipe_stage_reg_if.sv
// Bundle of the handshake, datapath and debug-counter signals around one pipe_stage_reg.
// The slave modport is the stage itself; the master modport is its surrounding environment.
interface pipe_stage_reg_if #(
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int META_W = 8,
  parameter int CNT_W  = 16
) ();

  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [ILEN-1:0]   in_inst;
  logic [META_W-1:0] in_meta;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [ILEN-1:0]   out_inst;
  logic [META_W-1:0] out_meta;
  logic              cnt_clr;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output in_valid, in_pc, in_inst, in_meta, flush, out_ready, cnt_clr,
    input  in_ready, out_valid, out_pc, out_inst, out_meta, stall_cnt
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_meta, flush, out_ready, cnt_clr,
    output in_ready, out_valid, out_pc, out_inst, out_meta, stall_cnt
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register (PC/instruction/metadata) with flush-to-NOP and a stall counter.
// Define PIPE_STAGE_SKID_EN to build a one-entry skid buffer and a registered in_ready.
module pipe_stage_reg #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              META_W   = 8,
  parameter logic [ILEN-1:0] NOP_INST = ILEN'(32'h00000013),
  parameter int              CNT_W    = 16
) (
  input logic            clk,
  input logic            rst,
  pipe_stage_reg_if.slave bus
);

  logic              w_in_ready;
  logic              w_accept;
  logic              w_consume;

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [ILEN-1:0]   r_inst;
  logic [META_W-1:0] r_meta;
  logic              w_valid_d;
  logic [XLEN-1:0]   w_pc_d;
  logic [ILEN-1:0]   w_inst_d;
  logic [META_W-1:0] w_meta_d;

  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_accept  = bus.in_valid & w_in_ready;
  assign w_consume = r_valid & bus.out_ready;

`ifndef PIPE_STAGE_SKID_EN

  // Ready whenever the main register is free or being drained; flush always swallows the input.
  assign w_in_ready = bus.flush | ~r_valid | bus.out_ready;

  always_comb begin
    w_valid_d = r_valid;
    w_pc_d    = r_pc;
    w_inst_d  = r_inst;
    w_meta_d  = r_meta;
    if (bus.flush) begin
      w_valid_d = 1'b0;
      w_pc_d    = '0;
      w_inst_d  = NOP_INST;
      w_meta_d  = '0;
    end else if (w_accept) begin
      w_valid_d = 1'b1;
      w_pc_d    = bus.in_pc;
      w_inst_d  = bus.in_inst;
      w_meta_d  = bus.in_meta;
    end else if (w_consume) begin
      w_valid_d = 1'b0;
      w_inst_d  = NOP_INST;
    end
  end

`else

  logic              r_skid_valid;
  logic [XLEN-1:0]   r_skid_pc;
  logic [ILEN-1:0]   r_skid_inst;
  logic [META_W-1:0] r_skid_meta;
  logic              w_skid_valid_d;
  logic [XLEN-1:0]   w_skid_pc_d;
  logic [ILEN-1:0]   w_skid_inst_d;
  logic [META_W-1:0] w_skid_meta_d;
  logic              r_in_ready;

  assign w_in_ready = r_in_ready;

  always_comb begin
    w_valid_d      = r_valid;
    w_pc_d         = r_pc;
    w_inst_d       = r_inst;
    w_meta_d       = r_meta;
    w_skid_valid_d = r_skid_valid;
    w_skid_pc_d    = r_skid_pc;
    w_skid_inst_d  = r_skid_inst;
    w_skid_meta_d  = r_skid_meta;
    if (bus.flush) begin
      w_valid_d      = 1'b0;
      w_pc_d         = '0;
      w_inst_d       = NOP_INST;
      w_meta_d       = '0;
      w_skid_valid_d = 1'b0;
    end else if (!r_valid || w_consume) begin
      // Main register frees up: the older skid beat always goes first to keep ordering.
      if (r_skid_valid) begin
        w_valid_d = 1'b1;
        w_pc_d    = r_skid_pc;
        w_inst_d  = r_skid_inst;
        w_meta_d  = r_skid_meta;
        if (w_accept) begin
          w_skid_pc_d   = bus.in_pc;
          w_skid_inst_d = bus.in_inst;
          w_skid_meta_d = bus.in_meta;
        end else begin
          w_skid_valid_d = 1'b0;
        end
      end else if (w_accept) begin
        w_valid_d = 1'b1;
        w_pc_d    = bus.in_pc;
        w_inst_d  = bus.in_inst;
        w_meta_d  = bus.in_meta;
      end else if (w_consume) begin
        w_valid_d = 1'b0;
        w_inst_d  = NOP_INST;
      end
    end else if (w_accept) begin
      w_skid_valid_d = 1'b1;
      w_skid_pc_d    = bus.in_pc;
      w_skid_inst_d  = bus.in_inst;
      w_skid_meta_d  = bus.in_meta;
    end
  end

  // in_ready is the registered inverse of the next skid state, so it never depends on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_inst  <= NOP_INST;
      r_skid_meta  <= '0;
      r_in_ready   <= 1'b1;
    end else begin
      r_skid_valid <= w_skid_valid_d;
      r_skid_pc    <= w_skid_pc_d;
      r_skid_inst  <= w_skid_inst_d;
      r_skid_meta  <= w_skid_meta_d;
      r_in_ready   <= ~w_skid_valid_d;
    end
  end

`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= NOP_INST;
      r_meta  <= '0;
    end else begin
      r_valid <= w_valid_d;
      r_pc    <= w_pc_d;
      r_inst  <= w_inst_d;
      r_meta  <= w_meta_d;
    end
  end

  // Counts back-pressured cycles; a flush cycle is not a stall, clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (bus.cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (r_valid && !bus.out_ready && !bus.flush && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_pc    = r_pc;
  assign bus.out_inst  = r_inst;
  assign bus.out_meta  = r_meta;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, back-pressure, skid, flush and counter saturation.
// Skid-specific scenarios are built when PIPE_STAGE_SKID_EN is defined.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.XLEN(32), .ILEN(32), .META_W(8), .CNT_W(16)) bus ();
  pipe_stage_reg_if #(.XLEN(32), .ILEN(32), .META_W(8), .CNT_W(4))  bus4 ();

  pipe_stage_reg #(.XLEN(32), .ILEN(32), .META_W(8), .NOP_INST(32'h00000013), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipe_stage_reg #(.XLEN(32), .ILEN(32), .META_W(8), .NOP_INST(32'h00000013), .CNT_W(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  task automatic test_reset;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_pc = 32'h44; bus.in_inst = 32'hDEAD_0044; bus.in_meta = 8'h33;
    bus.out_ready = 1'b0;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rst_preload_valid got=%0b exp=1", bus.out_valid); end
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", bus.out_valid); end
    total++; if (bus.out_inst !== NOP) begin bad++; $display("FAIL rst_inst got=%h exp=%h", bus.out_inst, NOP); end
    total++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", bus.out_pc); end
    total++; if (bus.out_meta !== 8'h0) begin bad++; $display("FAIL rst_meta got=%h exp=0", bus.out_meta); end
    total++; if (bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", bus.stall_cnt); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    $display("reset: mid-run reset applied and released");
  endtask

  task automatic test_stream;
    logic [31:0] pcs [4];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8; pcs[3] = 32'hC;
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%0b exp=1", k-1, bus.out_valid); end
        total++; if (bus.out_pc !== pcs[k-1]) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", k-1, bus.out_pc, pcs[k-1]); end
        total++; if (bus.out_inst !== (32'h1000 | pcs[k-1])) begin bad++; $display("FAIL stream_inst[%0d] got=%h exp=%h", k-1, bus.out_inst, 32'h1000 | pcs[k-1]); end
        total++; if (bus.out_meta !== (pcs[k-1][7:0] + 8'd1)) begin bad++; $display("FAIL stream_meta[%0d] got=%h exp=%h", k-1, bus.out_meta, pcs[k-1][7:0] + 8'd1); end
        $display("stream: beat pc=%h out_pc=%h", pcs[k-1], bus.out_pc);
      end
      if (k < 4) begin
        bus.in_valid = 1'b1; bus.in_pc = pcs[k]; bus.in_inst = 32'h1000 | pcs[k]; bus.in_meta = pcs[k][7:0] + 8'd1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%0b exp=1", k, bus.in_ready); end
        @(negedge clk);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain_valid got=%0b exp=0", bus.out_valid); end
    total++; if (bus.out_inst !== NOP) begin bad++; $display("FAIL stream_drain_inst got=%h exp=%h", bus.out_inst, NOP); end
    total++; if (bus.out_pc !== 32'hC) begin bad++; $display("FAIL stream_drain_pc got=%h exp=0000000c", bus.out_pc); end
    $display("stream: drained, out_valid=%0b", bus.out_valid);
  endtask

  task automatic test_backpressure;
    logic exp_ready;
`ifdef PIPE_STAGE_SKID_EN
    exp_ready = 1'b1;
`else
    exp_ready = 1'b0;
`endif
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_pc = 32'h40; bus.in_inst = 32'hAAAA_0001; bus.in_meta = 8'h5A;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_load_valid got=%0b exp=1", bus.out_valid); end
    total++; if (bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL bp_cnt0 got=%0d exp=0", bus.stall_cnt); end
    total++; if (bus.in_ready !== exp_ready) begin bad++; $display("FAIL bp_in_ready got=%0b exp=%0b", bus.in_ready, exp_ready); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total++; if (bus.out_pc !== 32'h40 || bus.out_inst !== 32'hAAAA_0001 || bus.out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold[%0d] got pc=%h inst=%h v=%0b exp pc=40 inst=aaaa0001 v=1", k, bus.out_pc, bus.out_inst, bus.out_valid);
      end
      total++; if (bus.stall_cnt !== 16'(k)) begin bad++; $display("FAIL bp_cnt[%0d] got=%0d exp=%0d", k, bus.stall_cnt, k); end
      $display("backpressure: cycle %0d pc=%h stall_cnt=%0d", k, bus.out_pc, bus.stall_cnt);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%0b exp=0", bus.out_valid); end
    total++; if (bus.stall_cnt !== 16'd5) begin bad++; $display("FAIL bp_cnt_final got=%0d exp=5", bus.stall_cnt); end
    $display("backpressure: released, stall_cnt=%0d", bus.stall_cnt);
  endtask

`ifdef PIPE_STAGE_SKID_EN
  task automatic test_skid;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_pc = 32'h10; bus.in_inst = 32'hBBBB_0010; bus.in_meta = 8'h10;
    @(negedge clk);
    total++; if (bus.out_pc !== 32'h10 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL skid_first got pc=%h v=%0b exp pc=10 v=1", bus.out_pc, bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL skid_ready_pre got=%0b exp=1", bus.in_ready); end
    bus.out_ready = 1'b0;
    bus.in_pc = 32'h14; bus.in_inst = 32'hBBBB_0014; bus.in_meta = 8'h14;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL skid_ready_drop got=%0b exp=0", bus.in_ready); end
    total++; if (bus.out_pc !== 32'h10) begin bad++; $display("FAIL skid_hold got=%h exp=10", bus.out_pc); end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.out_pc !== 32'h14 || bus.out_inst !== 32'hBBBB_0014 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL skid_second got pc=%h inst=%h v=%0b exp pc=14 inst=bbbb0014 v=1", bus.out_pc, bus.out_inst, bus.out_valid);
    end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL skid_ready_back got=%0b exp=1", bus.in_ready); end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL skid_drain got=%0b exp=0", bus.out_valid); end
    $display("skid: delivered 10 then 14, drained");
  endtask
`endif

  task automatic test_flush;
    logic exp_ready;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_pc = 32'h18; bus.in_inst = 32'hCCCC_0018; bus.in_meta = 8'h18;
    bus.out_ready = 1'b0;
    @(negedge clk);
`ifdef PIPE_STAGE_SKID_EN
    bus.in_pc = 32'h1C; bus.in_inst = 32'hCCCC_001C; bus.in_meta = 8'h1C;
    @(negedge clk);
    exp_ready = 1'b0;
`else
    exp_ready = 1'b1;
`endif
    bus.flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_pc = 32'h20; bus.in_inst = 32'hCCCC_0020; bus.in_meta = 8'h20;
    #1;
    total++; if (bus.in_ready !== exp_ready) begin bad++; $display("FAIL flush_in_ready got=%0b exp=%0b", bus.in_ready, exp_ready); end
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", bus.out_valid); end
    total++; if (bus.out_inst !== NOP) begin bad++; $display("FAIL flush_inst got=%h exp=%h", bus.out_inst, NOP); end
    total++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL flush_pc got=%h exp=0", bus.out_pc); end
    total++; if (bus.out_meta !== 8'h0) begin bad++; $display("FAIL flush_meta got=%h exp=0", bus.out_meta); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_after got=%0b exp=1", bus.in_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0) begin
        bad++; $display("FAIL flush_quiet[%0d] got v=%0b pc=%h exp v=0 pc=0", k, bus.out_valid, bus.out_pc);
      end
    end
    $display("flush: stage emptied, pc 20 never delivered");
  endtask

  task automatic test_cnt_sat;
    @(negedge clk);
    bus4.in_valid = 1'b1; bus4.in_pc = 32'h30; bus4.in_inst = 32'hEEEE_0030; bus4.in_meta = 8'h30;
    bus4.out_ready = 1'b0;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    total++; if (bus4.stall_cnt !== 4'd0) begin bad++; $display("FAIL sat_cnt0 got=%0d exp=0", bus4.stall_cnt); end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      total++; if (bus4.stall_cnt !== ((k > 15) ? 4'd15 : 4'(k))) begin
        bad++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", k, bus4.stall_cnt, (k > 15) ? 15 : k);
      end
    end
    $display("cnt_sat: after 20 stalls stall_cnt=%0d", bus4.stall_cnt);
    bus4.cnt_clr = 1'b1;
    @(negedge clk);
    bus4.cnt_clr = 1'b0;
    total++; if (bus4.stall_cnt !== 4'd0) begin bad++; $display("FAIL sat_clr got=%0d exp=0", bus4.stall_cnt); end
    @(negedge clk);
    total++; if (bus4.stall_cnt !== 4'd1) begin bad++; $display("FAIL sat_resume got=%0d exp=1", bus4.stall_cnt); end
    $display("cnt_sat: cleared, resumed count=%0d", bus4.stall_cnt);
    bus4.out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0; bus.in_meta = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0; bus.cnt_clr = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_pc = '0; bus4.in_inst = '0; bus4.in_meta = '0;
    bus4.flush = 1'b0; bus4.out_ready = 1'b0; bus4.cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.out_valid !== 1'b0 || bus.out_inst !== NOP || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL por_state got v=%0b inst=%h rdy=%0b exp v=0 inst=%h rdy=1", bus.out_valid, bus.out_inst, bus.in_ready, NOP);
    end
    rst = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
`ifdef PIPE_STAGE_SKID_EN
    test_skid();
`endif
    test_flush();
    test_cnt_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
